uart_tx_feeder: RTL and testbench

//  Upstream stage of the UART transmitter on the FPGA top level. It debounces the raw TX button.
//  On each clean press it captures the 8 switches into a small FIFO.
//  It then launches queued bytes into the UART (data_in/En_btn), paced by tx_busy.

---
 rtl/uart_tx_feeder_if.sv | 29 ++
 rtl/uart_tx_feeder.sv | 172 +++++++++++++++++
 tb/tb_uart_tx_feeder.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_feeder_if.sv
// Signal bundle between the TX button/switch front end, the byte feeder and the UART transmitter.
// The master modport is the feeder itself; the slave modport is the board/UART side.
interface uart_tx_feeder_if #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic              btn;
  logic [DATA_W-1:0] sw;
  logic              tx_busy;
  logic [DATA_W-1:0] data_in;
  logic              En_btn;
  logic [CNT_W-1:0]  fifo_count;
  logic              overflow;
  logic [1:0]        dbg_state;

  // En_btn is a request that stays high until tx_busy is observed high; that sample is the
  // acknowledge. A new request is only raised after tx_busy has been seen low again.
  modport master (
    input  btn, sw, tx_busy,
    output data_in, En_btn, fifo_count, overflow, dbg_state
  );

  modport slave (
    output btn, sw, tx_busy,
    input  data_in, En_btn, fifo_count, overflow, dbg_state
  );
endinterface

// File: rtl/uart_tx_feeder.sv
// Debounces the TX button, queues the switch byte on every clean press and feeds queued
// bytes to the UART one at a time, paced by tx_busy.
module uart_tx_feeder #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int FIFO_DEPTH      = 4,
  parameter int DATA_W          = 8
) (
  input  logic             clk_100m,
  input  logic             rst,
  uart_tx_feeder_if.master bus
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DB_W-1:0]  DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_STROBE    = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_e;

  logic              sync1_q, sync2_q;
  logic              db_level_q, db_level_d;
  logic              db_prev_q;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic              push;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              full, push_ok, pop;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              en_q, en_d;

  // btn is asynchronous to clk_100m
  always_ff @(posedge clk_100m) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= bus.btn;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    db_level_d = db_level_q;
    db_cnt_d   = '0;
    if (sync2_q != db_level_q) begin
      if (db_cnt_q == DB_MAX) begin
        db_level_d = ~db_level_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_100m) begin
    if (rst) begin
      db_level_q <= 1'b0;
      db_cnt_q   <= '0;
      db_prev_q  <= 1'b0;
    end else begin
      db_level_q <= db_level_d;
      db_cnt_q   <= db_cnt_d;
      db_prev_q  <= db_level_q;
    end
  end

  // One-cycle strobe on the rising edge of the debounced level; release is ignored.
  assign push = db_level_q & ~db_prev_q;

  // A push into a full queue still succeeds when the launcher pops in the same cycle.
  assign full    = (count_q == CNT_FULL);
  assign push_ok = push & (~full | pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    overflow_d = overflow_q | (push & ~push_ok);
    count_d    = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_100m) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: entries are only visible through the pointers.
  always_ff @(posedge clk_100m) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= bus.sw;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    en_d    = en_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if ((count_q != '0) && !bus.tx_busy) begin
          pop     = 1'b1;
          data_d  = mem_q[rd_ptr_q];
          en_d    = 1'b1;
          state_d = ST_STROBE;
        end
      end
      ST_STROBE: begin
        if (bus.tx_busy) begin
          en_d    = 1'b0;
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (!bus.tx_busy) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        en_d    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_100m) begin
    if (rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      en_q    <= en_d;
    end
  end

  assign bus.data_in    = data_q;
  assign bus.En_btn     = en_q;
  assign bus.fifo_count = count_q;
  assign bus.overflow   = overflow_q;
  assign bus.dbg_state  = state_q;

  a_no_pop_empty: assert property (@(posedge clk_100m) disable iff (rst)
    pop |-> (count_q != '0));
  a_count_bound: assert property (@(posedge clk_100m) disable iff (rst)
    count_q <= CNT_FULL);

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a short debounce window and a simple UART busy model.
`timescale 1ns/1ps
module tb_uart_tx_feeder;

  localparam int DB    = 8;
  localparam int DEPTH = 4;
  localparam int W     = 8;

  logic clk_100m = 1'b0;
  logic rst      = 1'b1;
  always #5 clk_100m = ~clk_100m;

  uart_tx_feeder_if #(.DATA_W(W), .FIFO_DEPTH(DEPTH)) bus ();

  uart_tx_feeder #(
    .DEBOUNCE_CYCLES(DB),
    .FIFO_DEPTH     (DEPTH),
    .DATA_W         (W)
  ) dut (
    .clk_100m(clk_100m),
    .rst     (rst),
    .bus     (bus)
  );

  // UART model: busy two cycles after En_btn, held for 20 cycles; force_busy stalls it.
  int   hold = 0;
  int   dly  = 0;
  logic force_busy = 1'b0;
  assign bus.tx_busy = force_busy | (hold > 0);

  always @(posedge clk_100m) begin
    if (hold > 0) begin
      hold <= hold - 1;
    end else if (dly > 0) begin
      dly <= dly - 1;
      if (dly == 1) hold <= 20;
    end else if (bus.En_btn === 1'b1) begin
      dly <= 1;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk_100m);
    #1;
  endtask

  // Scoreboard: every new request must carry the oldest expected byte.
  logic en_prev = 1'b0;
  always @(negedge clk_100m) begin
    if (bus.En_btn === 1'b1 && en_prev !== 1'b1) begin
      check("launch_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("launch_data", 32'(bus.data_in), 32'(exp_q.pop_front()));
    end
    en_prev = bus.En_btn;
  end

  task automatic press(input logic [W-1:0] val, input int high_n, input int low_n);
    bus.sw  = val;
    bus.btn = 1'b1;
    repeat (high_n) tick();
    bus.btn = 1'b0;
    repeat (low_n) tick();
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!(bus.fifo_count == 0 && bus.tx_busy == 1'b0 && bus.En_btn == 1'b0) && n < 600) begin
      tick();
      n++;
    end
    check(name, 32'(n < 600), 32'd1);
    repeat (3) tick();
  endtask

  task automatic wait_count(input string name, input int exp_n);
    int n;
    n = 0;
    while (bus.fifo_count == 0 && n < 40) begin
      tick();
      n++;
    end
    check(name, 32'(n), 32'(exp_n));
  endtask

  typedef struct {
    int         high_n;
    logic [W-1:0] sw;
    int         exp_count;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int prev_count;
    int m;

    vecs[0] = '{3,  8'hE1, 0, 1'b0};
    vecs[1] = '{7,  8'hE2, 0, 1'b0};
    vecs[2] = '{8,  8'h01, 1, 1'b0};
    vecs[3] = '{12, 8'h02, 2, 1'b0};
    vecs[4] = '{1,  8'hE3, 2, 1'b0};
    vecs[5] = '{7,  8'hE4, 2, 1'b0};
    vecs[6] = '{9,  8'h03, 3, 1'b0};
    vecs[7] = '{20, 8'h04, 4, 1'b0};
    vecs[8] = '{10, 8'h05, 4, 1'b1};
    vecs[9] = '{8,  8'hE5, 4, 1'b1};

    // Button held through reset
    rst     = 1'b1;
    bus.btn = 1'b1;
    bus.sw  = 8'hFF;
    repeat (3) begin
      tick();
      check("rst_data_in", 32'(bus.data_in), 32'd0);
      check("rst_en_btn", 32'(bus.En_btn), 32'd0);
      check("rst_fifo_count", 32'(bus.fifo_count), 32'd0);
      check("rst_overflow", 32'(bus.overflow), 32'd0);
    end
    exp_q.push_back(8'hFF);
    rst = 1'b0;
    wait_count("held_press_latency", 11);
    check("held_press_count", 32'(bus.fifo_count), 32'd1);
    tick();
    check("held_launch_en", 32'(bus.En_btn), 32'd1);
    check("held_launch_data", 32'(bus.data_in), 32'hFF);
    check("held_launch_count", 32'(bus.fifo_count), 32'd0);
    bus.btn = 1'b0;
    wait_idle("idle_after_held");

    // Bouncy press
    exp_q.push_back(8'hA5);
    bus.sw = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      bus.btn = 1'b1;
      repeat (3) tick();
      bus.btn = 1'b0;
      repeat (3) tick();
    end
    bus.btn = 1'b1;
    wait_count("bounce_press_latency", 11);
    check("bounce_count", 32'(bus.fifo_count), 32'd1);
    tick();
    check("bounce_en", 32'(bus.En_btn), 32'd1);
    check("bounce_data", 32'(bus.data_in), 32'hA5);
    check("bounce_count_popped", 32'(bus.fifo_count), 32'd0);
    m = 0;
    while (bus.tx_busy !== 1'b1 && m < 10) begin
      check("strobe_held", 32'(bus.En_btn), 32'd1);
      tick();
      m++;
    end
    check("busy_seen", 32'(m < 10), 32'd1);
    tick();
    check("strobe_dropped", 32'(bus.En_btn), 32'd0);
    repeat (10) tick();
    bus.btn = 1'b0;
    wait_idle("idle_after_bounce");

    // Glitch rejection, ordering and overflow with the UART stalled
    force_busy = 1'b1;
    prev_count = 0;
    foreach (vecs[i]) begin
      if (vecs[i].exp_count > prev_count) exp_q.push_back(vecs[i].sw);
      prev_count = vecs[i].exp_count;
      press(vecs[i].sw, vecs[i].high_n, 20);
      check($sformatf("vec%0d_count", i), 32'(bus.fifo_count), 32'(vecs[i].exp_count));
      check($sformatf("vec%0d_overflow", i), 32'(bus.overflow), 32'(vecs[i].exp_ovf));
      check($sformatf("vec%0d_no_en", i), 32'(bus.En_btn), 32'd0);
    end
    force_busy = 1'b0;
    wait_idle("idle_after_table");
    check("overflow_sticky", 32'(bus.overflow), 32'd1);

    // Push into a full FIFO in the same cycle as a pop
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("overflow_cleared", 32'(bus.overflow), 32'd0);
    force_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'(8'h11 + i));
      press(8'(8'h11 + i), 10, 20);
    end
    check("full_before", 32'(bus.fifo_count), 32'd4);
    exp_q.push_back(8'h5A);
    bus.sw  = 8'h5A;
    bus.btn = 1'b1;
    repeat (10) tick();
    force_busy = 1'b0;
    tick();
    check("full_push_pop_count", 32'(bus.fifo_count), 32'd4);
    check("full_push_pop_overflow", 32'(bus.overflow), 32'd0);
    check("full_push_pop_en", 32'(bus.En_btn), 32'd1);
    repeat (5) tick();
    bus.btn = 1'b0;
    wait_idle("idle_after_full");
    check("full_overflow_final", 32'(bus.overflow), 32'd0);

    // Reset while waiting for the UART to finish, with bytes still queued
    force_busy = 1'b1;
    press(8'hB1, 10, 20);
    press(8'hB2, 10, 20);
    press(8'hB3, 10, 20);
    check("pre_reset_count", 32'(bus.fifo_count), 32'd3);
    exp_q.push_back(8'hB1);
    force_busy = 1'b0;
    m = 0;
    while (bus.En_btn !== 1'b1 && m < 10) begin tick(); m++; end
    check("b1_launched", 32'(m < 10), 32'd1);
    m = 0;
    while (bus.En_btn !== 1'b0 && m < 10) begin tick(); m++; end
    check("b1_acked", 32'(m < 10), 32'd1);
    force_busy = 1'b1;
    rst = 1'b1;
    tick();
    check("midrst_count", 32'(bus.fifo_count), 32'd0);
    check("midrst_en", 32'(bus.En_btn), 32'd0);
    check("midrst_data", 32'(bus.data_in), 32'd0);
    tick();
    rst = 1'b0;
    exp_q.push_back(8'hC3);
    bus.sw  = 8'hC3;
    bus.btn = 1'b1;
    wait_count("post_rst_press_latency", 11);
    check("post_rst_count", 32'(bus.fifo_count), 32'd1);
    repeat (5) begin
      check("post_rst_wait_busy", 32'(bus.En_btn), 32'd0);
      tick();
    end
    bus.btn    = 1'b0;
    force_busy = 1'b0;
    wait_idle("idle_after_midrst");

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule
